// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: start bit, WIDTH data bits MSB first,
// optional stop bit, then a one-entry valid/ready output buffer.
module sipo_frame_ctrl #(
    parameter int WIDTH      = 4,
    parameter int STOP_CHECK = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_serial_valid,
    input  logic             i_serial_in,
    input  logic             i_out_ready,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_parallel_out,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic [7:0]       o_frame_count
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_parallel_out;
    logic             r_out_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic [7:0]       r_frame_count;

    logic             w_start;
    logic             w_shift_en;
    logic             w_complete;
    logic             w_stop_bad;
    logic             w_drain;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;

    assign w_shift_next = {r_shift[WIDTH-2:0], i_serial_in};

    // Without a stop bit the word completes on the last data bit, before the shift lands.
    assign w_word  = (STOP_CHECK != 0) ? r_shift : w_shift_next;
    assign w_drain = r_out_valid & i_out_ready;
    assign w_load  = w_complete & (~r_out_valid | i_out_ready);
    assign w_drop  = w_complete & r_out_valid & ~i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_complete   = 1'b0;
        w_stop_bad   = 1'b0;
        if (i_serial_valid) begin
            case (r_state)
                IDLE: begin
                    if (i_serial_in) begin
                        w_start      = 1'b1;
                        w_next_state = DATA;
                    end
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        if (STOP_CHECK != 0) begin
                            w_next_state = STOP;
                        end else begin
                            w_next_state = IDLE;
                            w_complete   = 1'b1;
                        end
                    end
                end
                STOP: begin
                    w_next_state = IDLE;
                    if (i_serial_in) begin
                        w_stop_bad = 1'b1;
                    end else begin
                        w_complete = 1'b1;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_shift_en) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    // A load on the same edge as a drain keeps the buffer occupied with the new word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_parallel_out <= '0;
            r_out_valid    <= 1'b0;
            r_frame_count  <= 8'd0;
        end else if (w_load) begin
            r_parallel_out <= w_word;
            r_out_valid    <= 1'b1;
            r_frame_count  <= r_frame_count + 8'd1;
        end else if (w_drain) begin
            r_out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_parallel_out = r_parallel_out;
    assign o_out_valid    = r_out_valid;
    assign o_busy         = (r_state != IDLE);
    assign o_frame_err    = r_frame_err;
    assign o_overrun      = r_overrun;
    assign o_frame_count  = r_frame_count;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: frame-level reference model fed by the
// driver, negedge monitor comparing every output against it.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sv;
    logic             si;
    logic             ordy;
    logic             clr;
    logic [WIDTH-1:0] parOut;
    logic             outValid;
    logic             busy;
    logic             frameErr;
    logic             overrun;
    logic [7:0]       frameCount;

    int checkCount = 0;
    int passCount  = 0;

    bit               monitorOn = 0;
    bit               startNow  = 0;
    bit               endNow    = 0;
    bit               endBad    = 0;
    logic [WIDTH-1:0] endWord   = '0;
    int               readyMode = 1;
    bit               randomClr = 0;
    bit               clrNext   = 0;

    bit               mFull, mBusy, mErr, mOverrun;
    int               mCount;
    logic [WIDTH-1:0] expQ[$];

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(WIDTH), .STOP_CHECK(1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_serial_valid (sv),
        .i_serial_in    (si),
        .i_out_ready    (ordy),
        .i_clr_err      (clr),
        .o_parallel_out (parOut),
        .o_out_valid    (outValid),
        .o_busy         (busy),
        .o_frame_err    (frameErr),
        .o_overrun      (overrun),
        .o_frame_count  (frameCount)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: the driver flags where frames start and end, the model
    // decides at frame level whether the word is buffered, dropped or rejected.
    always @(posedge clk) begin
        bit drain, loaded, drop;
        if (rst) begin
            mFull = 0; mBusy = 0; mErr = 0; mOverrun = 0; mCount = 0;
            expQ.delete();
        end else begin
            drain  = mFull && ordy;
            loaded = 0;
            drop   = 0;
            mErr   = 0;
            if (sv && startNow) mBusy = 1;
            if (sv && endNow) begin
                mBusy = 0;
                if (endBad) mErr = 1;
                else if (!mFull || drain) begin
                    expQ.push_back(endWord);
                    mCount = (mCount + 1) % 256;
                    loaded = 1;
                end else drop = 1;
            end
            if (loaded) mFull = 1;
            else if (drain) mFull = 0;
            if (drop) mOverrun = 1;
            else if (clr) mOverrun = 0;
        end
    end

    // Monitor: compare every output each cycle; pop the scoreboard on a transfer.
    always @(negedge clk) begin
        if (monitorOn && !rst) begin
            checkOutput("out_valid", int'(outValid), int'(mFull));
            checkOutput("busy", int'(busy), int'(mBusy));
            checkOutput("frame_err", int'(frameErr), int'(mErr));
            checkOutput("overrun", int'(overrun), int'(mOverrun));
            checkOutput("frame_count", int'(frameCount), mCount);
            if (outValid) begin
                if (expQ.size() == 0) checkOutput("scoreboard_nonempty", expQ.size(), 1);
                else begin
                    checkOutput("parallel_out", int'(parOut), int'(expQ[0]));
                    if (ordy) void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic driveCycle(input logic v, input logic b, input bit st, input bit en,
                              input int rdyOverride);
        @(posedge clk);
        #1;
        sv = v; si = b; startNow = st; endNow = en;
        case (readyMode)
            0:       ordy = 1'b0;
            1:       ordy = 1'b1;
            default: ordy = 1'($urandom_range(0, 1));
        endcase
        if (rdyOverride >= 0) ordy = rdyOverride[0];
        clr = clrNext | (randomClr && ($urandom_range(0, 9) == 0));
        clrNext = 0;
    endtask

    task automatic idleCycles(input int n, input bit zeros);
        for (int k = 0; k < n; k++) begin
            if (zeros) driveCycle(1'b1, 1'b0, 0, 0, -1);
            else driveCycle(1'b0, 1'($urandom), 0, 0, -1);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic stopBit,
                                 input int minGap, input int maxGap, input int endReady);
        logic [WIDTH+1:0] bits;
        bits = {1'b1, word, stopBit};
        for (int i = WIDTH + 1; i >= 0; i--) begin
            idleCycles($urandom_range(minGap, maxGap), 0);
            if (i == 0) begin
                endWord = word;
                endBad  = stopBit;
            end
            driveCycle(1'b1, bits[i], i == WIDTH + 1, i == 0, (i == 0) ? endReady : -1);
        end
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst = 1; sv = 0; startNow = 0; endNow = 0; clr = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        checkOutput("rst_parallel_out", int'(parOut), 0);
        checkOutput("rst_out_valid", int'(outValid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_frame_count", int'(frameCount), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1; sv = 0; si = 0; ordy = 0; clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("init_parallel_out", int'(parOut), 0);
        checkOutput("init_out_valid", int'(outValid), 0);
        checkOutput("init_frame_err", int'(frameErr), 0);
        checkOutput("init_frame_count", int'(frameCount), 0);
        @(posedge clk);
        #1;
        rst = 0;
        monitorOn = 1;

        $display("[TB] test 1: frame 1011, ready high");
        readyMode = 1;
        applyStimulus(4'b1011, 1'b0, 0, 0, -1);
        idleCycles(3, 0);

        $display("[TB] test 2: frame 1011 with 3-cycle gaps and idle zeros");
        idleCycles(2, 1);
        applyStimulus(4'b1011, 1'b0, 3, 3, -1);
        idleCycles(2, 1);

        $display("[TB] test 3: bad stop bit");
        applyStimulus(4'b0110, 1'b1, 0, 0, -1);
        idleCycles(3, 0);

        $display("[TB] test 4: overrun with consumer stalled");
        readyMode = 0;
        applyStimulus(4'b1011, 1'b0, 0, 0, -1);
        applyStimulus(4'b0110, 1'b0, 0, 0, -1);
        idleCycles(2, 0);
        clrNext = 1;
        idleCycles(2, 0);
        readyMode = 1;
        idleCycles(3, 0);

        $display("[TB] test 5: drain and load on the same edge");
        readyMode = 0;
        applyStimulus(4'b1100, 1'b0, 0, 0, -1);
        applyStimulus(4'b0110, 1'b0, 0, 0, 1);
        idleCycles(3, 0);
        readyMode = 1;
        idleCycles(3, 0);

        $display("[TB] test 6: reset mid-frame");
        driveCycle(1'b1, 1'b1, 1, 0, -1);
        driveCycle(1'b1, 1'b1, 0, 0, -1);
        driveCycle(1'b1, 1'b0, 0, 0, -1);
        resetPulse();
        applyStimulus(4'b0001, 1'b0, 0, 0, -1);
        idleCycles(3, 0);

        $display("[TB] random phase");
        readyMode = 2;
        randomClr = 1;
        for (int f = 0; f < 80; f++) begin
            applyStimulus(4'($urandom), 1'($urandom_range(0, 4) == 0), 0, 3, -1);
            idleCycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        randomClr = 0;
        readyMode = 1;
        idleCycles(6, 0);
        monitorOn = 0;

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Controller that sequences a WIDTH-bit serial-in/parallel-out shift path.
- Detects a start bit on a qualified serial stream and counts WIDTH data bits, MSB first.
- Optionally checks a stop bit, then delivers the word through a one-entry output buffer with a valid/ready handshake.
- Sits between a serial line sampler and the parallel consumer; reports framing errors and overruns.

Parameters:
- WIDTH, 4, data bits per frame; minimum 2.
- STOP_CHECK, 1, 1 = expect and check a stop bit after the data bits; 0 = no stop bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- serial_valid  input  1  qualifies serial_in for this cycle; nothing advances when low.
- serial_in  input  1  serial data bit.
- out_ready  input  1  consumer accepts parallel_out this cycle.
- clr_err  input  1  clears the sticky overrun flag.
- parallel_out  output  WIDTH  delivered word; stable while out_valid=1.
- out_valid  output  1  parallel_out holds an undelivered word.
- busy  output  1  state is not IDLE.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overrun  output  1  sticky: a completed word was dropped because the buffer was full.
- frame_count  output  8  count of words loaded into the output buffer; wraps 255 to 0.

Behaviour:
- Reset is sampled on the clk edge only. It forces state=IDLE and bit_cnt=0. All outputs go to 0: parallel_out=0, out_valid=0, frame_err=0, overrun=0, frame_count=0. The internal shift register is cleared.
- Reset mid-frame discards the partial word; no error is flagged.
- All state advances only on cycles where serial_valid=1. Gaps of any length are allowed anywhere in a frame.
- State IDLE:
  - serial_valid=1 and serial_in=1 (start bit): go to DATA, bit_cnt=0, clear shift register.
  - serial_in=0: ignored; stay in IDLE.
- State DATA, on each valid bit:
  - shift register <= {shift[WIDTH-2:0], serial_in}; bit_cnt increments.
  - On the WIDTH-th bit: go to STOP if STOP_CHECK=1; otherwise the frame completes on this edge.
- State STOP, on the valid bit:
  - serial_in=0: frame completes.
  - serial_in=1: frame_err=1 for exactly the next cycle, word discarded, go to IDLE. A start bit is not inferred from this bit.
- Frame completion (same edge; state returns to IDLE):
  - Buffer free (out_valid=0), or draining this cycle (out_valid=1 and out_ready=1): parallel_out <= assembled word, out_valid=1, frame_count++.
  - Buffer full and not draining: word dropped, overrun <= 1, parallel_out unchanged.
- Latency: the final bit accepted on edge N gives out_valid=1 in the cycle after edge N.
- Handshake:
  - Transfer occurs when out_valid=1 and out_ready=1; out_valid then clears on that edge unless a new word loads on the same edge.
  - parallel_out must not change while out_valid=1 without a transfer.
- overrun is sticky. clr_err=1 clears it on the next edge. If a set and clr_err occur on the same edge, the set wins.
- frame_err is not sticky and does not affect overrun or frame_count.
- busy is 1 in DATA and STOP.

Test Plan (WIDTH=4, STOP_CHECK=1):
1. out_ready=1; serial stream 1,1,0,1,1,0 on consecutive valid cycles -> one cycle after the stop bit: parallel_out=4'b1011, out_valid=1 for exactly 1 cycle, frame_count=1, frame_err=0.
2. Same stream with serial_valid low for 3 cycles between each bit, plus 0s while idle -> identical result; busy=1 from the start bit through the stop bit; nothing advances during gaps.
3. Stream 1,0,1,1,0 followed by stop bit 1 -> frame_err pulses for 1 cycle, out_valid stays 0, frame_count stays 0, state returns to IDLE.
4. out_ready=0; frame 1011 then frame 0110 -> parallel_out holds 4'b1011 and overrun=1. Pulse clr_err -> overrun=0. Raise out_ready -> one transfer, out_valid=0, frame_count=1.
5. Back-to-back frames with out_ready=1 exactly on the cycle the second frame completes -> first word transfers, second word (0110) loads on the same edge, out_valid stays 1, overrun=0, frame_count=2.
6. Assert rst for 1 cycle after the 2nd data bit -> all outputs 0 and busy=0; the next frame 1,0,0,0,1,0 gives parallel_out=4'b0001 with frame_count=1.
